// File: rtl/sig_sched_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sig_sched_pkg : shared types/constants for signal_scheduler      |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package sig_sched_pkg;

  localparam int DEF_NREQ  = 4;
  localparam int DEF_PAT_W = 8;
  localparam int DEF_LEN_W = 3;
  localparam int DEF_REP_W = 4;

  typedef logic state_t;
  localparam state_t ST_IDLE = 1'b0;
  localparam state_t ST_RUN  = 1'b1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sig_sched_arb.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sig_sched_arb : combinational requester selection                |
// | SIG_SCHED_FIXED_PRIO_EN selects fixed priority; Rev 1.0          |
// +------------------------------------------------------------------+
module sig_sched_arb
  import sig_sched_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int IDX_W = (NREQ > 1) ? clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] last,
  output logic [IDX_W-1:0] winner,
  output logic             valid
);

  assign valid = |req;

`ifdef SIG_SCHED_FIXED_PRIO_EN
  logic unused_last;
  assign unused_last = ^last;

  always_comb begin
    winner = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[IDX_W'(i)]) winner = IDX_W'(i);
    end
  end
`else
  // Walk farthest-to-nearest from last so the nearest requester after last is written last.
  always_comb begin
    winner = '0;
    for (int k = NREQ; k >= 1; k--) begin
      int cand;
      cand = (int'(last) + k) % NREQ;
      if (req[IDX_W'(cand)]) winner = IDX_W'(cand);
    end
  end
`endif

endmodule
`default_nettype wire

// File: rtl/signal_scheduler.sv
`default_nettype none
// +------------------------------------------------------------------+
// | signal_scheduler : shared serial pattern sequencer (RR arbitrated)|
// | Option macro SIG_SCHED_FIXED_PRIO_EN; Rev 1.0                    |
// +------------------------------------------------------------------+
module signal_scheduler
  import sig_sched_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int PAT_W = DEF_PAT_W,
  parameter int LEN_W = DEF_LEN_W,
  parameter int REP_W = DEF_REP_W,
  localparam int IDX_W = (NREQ > 1) ? clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*PAT_W-1:0] pat,
  input  logic [NREQ*LEN_W-1:0] len,
  input  logic [NREQ*REP_W-1:0] rep,
  input  logic                  abort,
  output logic [NREQ-1:0]       grant,
  output logic [IDX_W-1:0]      owner,
  output logic                  busy,
  output logic                  out,
  output logic                  out_valid,
  output logic                  done
);

  state_t             state_q, state_d;
  logic [NREQ-1:0]    grant_q, grant_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [PAT_W-1:0]   pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [REP_W-1:0]   rep_q, rep_d;
  logic [LEN_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [REP_W-1:0]   rep_cnt_q, rep_cnt_d;
  logic               done_q, done_d;

  logic [IDX_W-1:0]   arb_winner;
  logic               arb_valid;
  logic [LEN_W-1:0]   bit_idx;

  sig_sched_arb #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req    (req),
    .last   (last_q),
    .winner (arb_winner),
    .valid  (arb_valid)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      owner_q   <= '0;
      last_q    <= IDX_W'(NREQ - 1);
      pat_q     <= '0;
      len_q     <= '0;
      rep_q     <= '0;
      bit_cnt_q <= '0;
      rep_cnt_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      pat_q     <= pat_d;
      len_q     <= len_d;
      rep_q     <= rep_d;
      bit_cnt_q <= bit_cnt_d;
      rep_cnt_q <= rep_cnt_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = '0;
    owner_d   = owner_q;
    last_d    = last_q;
    pat_d     = pat_q;
    len_d     = len_q;
    rep_d     = rep_q;
    bit_cnt_d = bit_cnt_q;
    rep_cnt_d = rep_cnt_q;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          grant_d   = NREQ'(1) << arb_winner;
          owner_d   = arb_winner;
          last_d    = arb_winner;
          pat_d     = pat[int'(arb_winner)*PAT_W +: PAT_W];
          len_d     = len[int'(arb_winner)*LEN_W +: LEN_W];
          rep_d     = rep[int'(arb_winner)*REP_W +: REP_W];
          bit_cnt_d = '0;
          rep_cnt_d = '0;
          state_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        // Abort outranks completion, so an abort on the final bit yields no done.
        if (abort) begin
          state_d = ST_IDLE;
        end else if (bit_cnt_q == len_q) begin
          bit_cnt_d = '0;
          if (rep_cnt_q == rep_q) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            rep_cnt_d = rep_cnt_q + 1'b1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bit_idx = len_q - bit_cnt_q;

  always_comb begin
    busy      = (state_q == ST_RUN);
    out_valid = busy;
    out       = busy ? pat_q[bit_idx] : 1'b0;
    grant     = grant_q;
    owner     = owner_q;
    done      = done_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_signal_scheduler.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_signal_scheduler : randomized + directed bench with bit-queue |
// | reference model; Rev 1.0                                          |
// +------------------------------------------------------------------+
module tb_signal_scheduler;

  localparam int NREQ  = 4;
  localparam int PAT_W = 8;
  localparam int LEN_W = 3;
  localparam int REP_W = 4;
  localparam int IDX_W = 2;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*PAT_W-1:0] pat = '0;
  logic [NREQ*LEN_W-1:0] len = '0;
  logic [NREQ*REP_W-1:0] rep = '0;
  logic                  abort = 1'b0;
  logic [NREQ-1:0]       grant;
  logic [IDX_W-1:0]      owner;
  logic                  busy, out, out_valid, done;

  always #5 clk = ~clk;

  signal_scheduler #(
    .NREQ (NREQ), .PAT_W (PAT_W), .LEN_W (LEN_W), .REP_W (REP_W)
  ) dut (
    .clk (clk), .rst (rst), .req (req), .pat (pat), .len (len), .rep (rep),
    .abort (abort), .grant (grant), .owner (owner), .busy (busy),
    .out (out), .out_valid (out_valid), .done (done)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: a playback is the queue of bits still to be emitted.
  bit              m_busy = 0;
  bit              m_done = 0;
  logic [NREQ-1:0] m_grant = '0;
  int              m_owner = 0;
  int              m_last = NREQ - 1;
  bit              m_seq[$];

  logic [31:0]     cap = '0;
  int              cap_n = 0;
  int              done_cnt = 0;
  int              cyc = 0;
  logic [NREQ-1:0] glog[$];
  int              gcyc[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int pick_winner(input logic [NREQ-1:0] r, input int last);
`ifdef SIG_SCHED_FIXED_PRIO_EN
    for (int i = 0; i < NREQ; i++) if (r[i]) return i;
`else
    for (int k = 1; k <= NREQ; k++) if (r[(last + k) % NREQ]) return (last + k) % NREQ;
`endif
    return 0;
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (!rst) begin
      m_busy = 0; m_done = 0; m_grant = '0; m_owner = 0; m_last = NREQ - 1;
      m_seq.delete();
    end else begin
      m_grant = '0;
      m_done  = 0;
      if (m_busy) begin
        if (abort) begin
          m_busy = 0;
          m_seq.delete();
        end else begin
          void'(m_seq.pop_front());
          if (m_seq.size() == 0) begin
            m_busy = 0;
            m_done = 1;
          end
        end
      end else if (|req) begin
        int w, l, p;
        logic [PAT_W-1:0] pv;
        w  = pick_winner(req, m_last);
        pv = pat[w*PAT_W +: PAT_W];
        l  = int'(len[w*LEN_W +: LEN_W]) + 1;
        p  = int'(rep[w*REP_W +: REP_W]) + 1;
        for (int n = 0; n < p; n++)
          for (int b = l - 1; b >= 0; b--) m_seq.push_back(pv[b]);
        m_grant = 1 << w;
        m_owner = w;
        m_last  = w;
        m_busy  = 1;
      end
    end
    #1;
    check("grant", 32'(grant), 32'(m_grant));
    check("owner", 32'(owner), 32'(m_owner));
    check("busy", 32'(busy), 32'(m_busy));
    check("out_valid", 32'(out_valid), 32'(m_busy));
    check("out", 32'(out), m_busy ? 32'(m_seq[0]) : 32'd0);
    check("done", 32'(done), 32'(m_done));
    if (busy === 1'b1) begin
      cap = {cap[30:0], out};
      cap_n++;
    end
    if (done === 1'b1) done_cnt++;
    if (grant !== '0) begin
      glog.push_back(grant);
      gcyc.push_back(cyc);
    end
  end

  task automatic set_req(input int i, input logic [PAT_W-1:0] p,
                         input logic [LEN_W-1:0] l, input logic [REP_W-1:0] r);
    pat[i*PAT_W +: PAT_W] = p;
    len[i*LEN_W +: LEN_W] = l;
    rep[i*REP_W +: REP_W] = r;
    req[i] = 1'b1;
  endtask

  task automatic wait_done(input int limit, input string name);
    int n;
    n = 0;
    while (done !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=no_done required=done", name);
    end
  endtask

  logic [NREQ-1:0] exp_g [5];

  initial begin
`ifdef SIG_SCHED_FIXED_PRIO_EN
    exp_g = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`endif
    repeat (3) @(negedge clk);
    check("reset_outs", {26'd0, grant, owner}, 32'd0);
    check("reset_flags", {28'd0, busy, out, out_valid, done}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Single playback
    cap = '0; cap_n = 0; done_cnt = 0;
    set_req(0, 8'b00100111, 3'd5, 4'd0);
    @(negedge clk);
    req = '0;
    check("t1_grant", 32'(grant), 32'b0001);
    wait_done(20, "t1");
    check("t1_bits", cap, 32'b100111);
    check("t1_nbits", 32'(cap_n), 32'd6);
    check("t1_out_in_done", 32'(out), 32'd0);
    @(negedge clk);
    check("t1_done_pulse", 32'(done), 32'd0);

    // Repeat
    cap = '0; cap_n = 0;
    set_req(2, 8'b00000010, 3'd1, 4'd2);
    @(negedge clk);
    req = '0;
    check("t2_owner", 32'(owner), 32'd2);
    wait_done(30, "t2");
    check("t2_bits", cap, 32'b101010);
    check("t2_nbits", 32'(cap_n), 32'd6);

    // Round-robin from a fresh pointer
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < NREQ; i++) set_req(i, 8'($urandom), 3'd0, 4'd0);
    glog.delete(); gcyc.delete();
    repeat (12) @(negedge clk);
    req = '0;
    repeat (4) @(negedge clk);
    check("rr_count_ok", 32'(glog.size() >= 5), 32'd1);
    if (glog.size() >= 5) begin
      for (int i = 0; i < 5; i++) check($sformatf("rr_grant%0d", i), 32'(glog[i]), 32'(exp_g[i]));
      check("rr_spacing", 32'(gcyc[1] - gcyc[0]), 32'd2);
    end

    // Abort on the 3rd of 6 bits
    cap = '0; cap_n = 0; done_cnt = 0;
    set_req(1, 8'b00111010, 3'd5, 4'd0);
    @(negedge clk);
    req = '0;
    @(negedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("ab_busy", 32'(busy), 32'd0);
    check("ab_out", 32'(out), 32'd0);
    repeat (3) @(negedge clk);
    check("ab_nbits", 32'(cap_n), 32'd3);

    // Abort coincident with the last bit
    set_req(3, 8'b00000101, 3'd2, 4'd0);
    @(negedge clk);
    req = '0;
    @(negedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("ab_last_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("ab_no_done", 32'(done_cnt), 32'd0);

    // Reset during playback
    set_req(2, 8'hAA, 3'd7, 4'd3);
    @(negedge clk);
    req = '0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("rm_outs", {26'd0, grant, owner}, 32'd0);
    check("rm_flags", {28'd0, busy, out, out_valid, done}, 32'd0);
    cap = '0; cap_n = 0;
    set_req(0, 8'b00000001, 3'd0, 4'd0);
    @(negedge clk);
    req = '0;
    check("rm_grant", 32'(grant), 32'b0001);
    check("rm_owner", 32'(owner), 32'd0);
    wait_done(10, "rm");

    // Length boundaries
    cap = '0; cap_n = 0;
    set_req(1, 8'b10000001, 3'd7, 4'd0);
    @(negedge clk);
    req = '0;
    wait_done(20, "len7");
    check("len7_bits", cap, 32'h81);
    check("len7_nbits", 32'(cap_n), 32'd8);
    cap = '0; cap_n = 0;
    set_req(3, 8'hFF, 3'd0, 4'd0);
    @(negedge clk);
    req = '0;
    wait_done(10, "len0");
    check("len0_bits", cap, 32'd1);
    check("len0_nbits", 32'(cap_n), 32'd1);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      req   = ($urandom_range(0, 3) == 0) ? NREQ'($urandom) : '0;
      pat   = {$urandom()};
      len   = 12'($urandom);
      rep   = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h0101;
      abort = ($urandom_range(0, 24) == 0);
      rst   = ($urandom_range(0, 149) != 0);
    end
    @(negedge clk);
    req = '0; abort = 1'b0; rst = 1'b1;
    repeat (200) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/signal_scheduler.md
# signal_scheduler

Shares one serial output line between NREQ pattern-generator requesters. Each requester asks for a short bit pattern, a length and a repeat count. A round-robin arbiter grants one request at a time, and a small FSM then plays that pattern MSB-first, one bit per clock. The block sits above the fixed-pattern signal creators and replaces hard-wired counter/case generators with a single programmable, shared sequencer.

## Interface
- NREQ, 4, number of requesters (2..8)
- PAT_W, 8, max pattern length in bits
- LEN_W, 3, length field width; encoded length L = len+1 (1..PAT_W)
- REP_W, 4, repeat field width; plays = rep+1
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-low reset
- req  in  NREQ  per-requester request level; held until granted
- pat  in  NREQ*PAT_W  patterns, requester i at [i*PAT_W +: PAT_W]
- len  in  NREQ*LEN_W  encoded lengths, same packing
- rep  in  NREQ*REP_W  repeat counts, same packing
- abort  in  1  terminate the active playback
- grant  out  NREQ  one-hot, single-cycle grant pulse
- owner  out  clog2(NREQ)  index of current/last granted requester
- busy  out  1  high while in RUN
- out  out  1  serial pattern bit
- out_valid  out  1  equals busy
- done  out  1  single-cycle pulse after a completed playback

## Operation
- FSM states are IDLE and RUN.
- **Reset** (rst=0 at an edge):
  - state=IDLE; grant=0, owner=0, busy=0, out=0, out_valid=0, done=0.
  - RR pointer last=NREQ-1, so requester 0 wins first.
- **IDLE**:
  - If |req, on the edge: pick the winner by round-robin, searching from last+1 with wrap.
  - Register grant=onehot(winner), owner=winner, last=winner.
  - Latch the winner's pat/len/rep into pat_r/len_r/rep_r; bit_cnt=0, rep_cnt=0; state goes to RUN.
  - Without req, stay in IDLE.
- **RUN**:
  - out = pat_r[len_r - bit_cnt] (MSB of the L-bit field first).
  - Each edge:
    - If bit_cnt==len_r: bit_cnt=0 and rep_cnt++. Otherwise bit_cnt++.
    - If bit_cnt==len_r and rep_cnt==rep_r: state goes to IDLE and done is pulsed.
- **Outside RUN**: out=0.
- **Arithmetic**:
  - Counter bit_cnt is LEN_W bits; rep_cnt is REP_W bits. Neither ever wraps past its field.
  - Pattern bits above position len_r are ignored.
- **Abort**: abort=1 in RUN sends state to IDLE on the next edge with no done. Abort in IDLE is ignored.
- **Request drop**: a requester dropping req before grant is simply not served. Its req is not re-checked during RUN.
- **Reset mid-playback**: returns all outputs to reset values on that edge; no done.

## Timing
- Latency:
  - req seen in IDLE at edge k gives grant high in cycle k+1.
  - The first pattern bit is on out in cycle k+1 (busy=1).
  - Playback lasts (len+1)*(rep+1) cycles.
- done rises in the first IDLE cycle after the last bit, for one cycle.
- Back-to-back: a pending req in the done cycle is granted on the following edge. Transfers are separated by exactly one idle cycle.
- Simultaneous abort and last bit: abort wins; no done.
- pat/len/rep are sampled only at the grant edge. Changes during RUN have no effect.

## Configuration
- SIG_SCHED_FIXED_PRIO_EN:
  - Defined: fixed priority, lowest req index wins, pointer unused.
  - Undefined (default): round-robin as described above.
- Reset values and timing are identical in both modes.

## Structure
- Package sig_sched_pkg:
  - State encoding (IDLE=1'b0, RUN=1'b1).
  - Default parameter constants.
  - The clog2 helper function.
- Sub-module sig_sched_arb:
  - Combinational winner/valid from req and last.
  - Contains the SIG_SCHED_FIXED_PRIO_EN switch.
- Top contains the FSM, pattern/length/repeat registers and counters.

## Test plan
- **Single playback**: reset, then req[0] with pat=8'b00100111, len=5, rep=0. Expect grant=0001 one cycle, then out=1,0,0,1,1,1 on 6 busy cycles, then done=1 for one cycle with out=0.
- **Repeat**: req[2] with pat=8'b00000010, len=1, rep=2. Expect out=1,0,1,0,1,0, owner=2, done after 6 bits.
- **Round-robin**: req=1111 held, each pattern 1 bit, rep=0. Expect grants 0001,0010,0100,1000,0001 in order, one idle cycle between plays. With SIG_SCHED_FIXED_PRIO_EN defined, expect 0001 every grant.
- **Abort**: abort=1 on the 3rd bit of a 6-bit play. Expect busy=0 and out=0 next cycle, done never asserted. Abort coincident with the last bit also gives no done.
- **Reset mid-playback**: rst=0 during RUN. Expect all outputs 0 next cycle; the next req[0] is granted normally with owner=0.
- **Length boundary**: len=7, pat=8'b10000001, rep=0. Expect 8 bits 1,0,0,0,0,0,0,1. With len=0, pat=8'hFF, expect exactly one bit 1.
